// File: rtl/elixirchip_es1_spu_op_reduce.sv
// Multi-channel bit-reduction operator (OR / AND / XOR / popcount) with per-channel
// accumulation and a cke-gated LATENCY-stage output pipeline. Optional: ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN.
module elixirchip_es1_spu_op_reduce #(
   parameter int CHANNELS   = 4,
   parameter int DATA_BITS  = 8,
   parameter int COUNT_BITS = 16,
   parameter int LATENCY    = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cke,
   input  logic [1:0]                       s_mode,
   input  logic [CHANNELS*DATA_BITS-1:0]    s_data,
   input  logic [CHANNELS-1:0]              s_clear,
   input  logic                             s_valid,
   output logic [CHANNELS-1:0]              m_data,
   output logic [CHANNELS*COUNT_BITS-1:0]   m_count,
   output logic                             m_valid
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
   ,
   output logic [CHANNELS-1:0]              m_overflow
`endif
);

   typedef enum logic [1:0] {
      MODE_ANY    = 2'd0,
      MODE_ALL    = 2'd1,
      MODE_PARITY = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   localparam logic [COUNT_BITS:0] CNT_MAX = {1'b0, {COUNT_BITS{1'b1}}};

   function automatic logic [COUNT_BITS:0] popcount(input logic [DATA_BITS-1:0] w);
      logic [COUNT_BITS:0] n;
      n = '0;
      for (int i = 0; i < DATA_BITS; i++) begin
         n = n + {{COUNT_BITS{1'b0}}, w[i]};
      end
      return n;
   endfunction

   mode_e                            mode_q;
   mode_e                            mode_d;
   logic                             mode_chg;
   logic [CHANNELS-1:0]              acc_bool_q;
   logic [CHANNELS-1:0]              acc_bool_d;
   logic [CHANNELS*COUNT_BITS-1:0]   acc_cnt_q;
   logic [CHANNELS*COUNT_BITS-1:0]   acc_cnt_d;
   logic [CHANNELS-1:0]              data_d;

   // Pipeline stage 0 is the accumulator output stage; stage LATENCY-1 drives the ports.
   logic [CHANNELS-1:0]              st_data_q  [LATENCY];
   logic [CHANNELS*COUNT_BITS-1:0]   st_count_q [LATENCY];
   logic                             st_valid_q [LATENCY];

`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
   logic [CHANNELS-1:0]              ovf_q;
   logic [CHANNELS-1:0]              ovf_d;
   logic [CHANNELS-1:0]              st_ovf_q   [LATENCY];
`endif

   assign mode_d   = mode_e'(s_mode);
   assign mode_chg = (mode_d != mode_q);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [DATA_BITS-1:0]   word;
         logic                   clr;
         logic                   base_bool;
         logic [COUNT_BITS-1:0]  base_cnt;
         logic [COUNT_BITS:0]    sum;
         logic                   bool_d;
         logic [COUNT_BITS-1:0]  cnt_d;
         logic                   sat;

         assign word = s_data[gi*DATA_BITS +: DATA_BITS];
         // A mode change behaves exactly like a clear on every channel.
         assign clr  = s_clear[gi] | mode_chg;

         always_comb begin
            base_bool = clr ? (mode_d == MODE_ALL) : acc_bool_q[gi];
            base_cnt  = clr ? '0 : acc_cnt_q[gi*COUNT_BITS +: COUNT_BITS];
            sum       = {1'b0, base_cnt} + popcount(word);
            bool_d    = base_bool;
            cnt_d     = base_cnt;
            sat       = 1'b0;
            if (s_valid) begin
               case (mode_d)
                  MODE_ANY:    bool_d = base_bool | (|word);
                  MODE_ALL:    bool_d = base_bool & (&word);
                  MODE_PARITY: bool_d = base_bool ^ (^word);
                  default: begin
                     if (sum > CNT_MAX) begin
                        cnt_d = {COUNT_BITS{1'b1}};
                        sat   = 1'b1;
                     end else begin
                        cnt_d = sum[COUNT_BITS-1:0];
                     end
                  end
               endcase
            end
         end

         assign acc_bool_d[gi]                           = bool_d;
         assign acc_cnt_d[gi*COUNT_BITS +: COUNT_BITS]   = cnt_d;
         assign data_d[gi] = (mode_d == MODE_COUNT) ? (cnt_d != '0) : bool_d;

`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
         assign ovf_d[gi] = (clr ? 1'b0 : ovf_q[gi]) | sat;
`else
         logic unused_sat;
         assign unused_sat = sat;
`endif
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q     <= MODE_ANY;
         acc_bool_q <= '0;
         acc_cnt_q  <= '0;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
         ovf_q      <= '0;
`endif
      end else if (cke) begin
         mode_q     <= mode_d;
         acc_bool_q <= acc_bool_d;
         acc_cnt_q  <= acc_cnt_d;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
         ovf_q      <= ovf_d;
`endif
      end
   end

   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               st_data_q[gi]  <= '0;
               st_count_q[gi] <= '0;
               st_valid_q[gi] <= 1'b0;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
               st_ovf_q[gi]   <= '0;
`endif
            end else if (cke) begin
               if (gi == 0) begin
                  st_data_q[gi]  <= data_d;
                  st_count_q[gi] <= acc_cnt_d;
                  st_valid_q[gi] <= s_valid;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
                  st_ovf_q[gi]   <= ovf_d;
`endif
               end else begin
                  st_data_q[gi]  <= st_data_q[(gi == 0) ? 0 : gi-1];
                  st_count_q[gi] <= st_count_q[(gi == 0) ? 0 : gi-1];
                  st_valid_q[gi] <= st_valid_q[(gi == 0) ? 0 : gi-1];
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
                  st_ovf_q[gi]   <= st_ovf_q[(gi == 0) ? 0 : gi-1];
`endif
               end
            end
         end
      end
   endgenerate

   assign m_data  = st_data_q[LATENCY-1];
   assign m_count = st_count_q[LATENCY-1];
   assign m_valid = st_valid_q[LATENCY-1];
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
   assign m_overflow = st_ovf_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_reduce.sv
// Randomized and directed bench for elixirchip_es1_spu_op_reduce (CHANNELS=2, DATA_BITS=8,
// COUNT_BITS=4, LATENCY=2) checked against a cycle-level behavioural model.
module tb_elixirchip_es1_spu_op_reduce;

   localparam int CH  = 2;
   localparam int DB  = 8;
   localparam int CB  = 4;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              cke;
   logic [1:0]        s_mode;
   logic [CH*DB-1:0]  s_data;
   logic [CH-1:0]     s_clear;
   logic              s_valid;
   logic [CH-1:0]     m_data;
   logic [CH*CB-1:0]  m_count;
   logic              m_valid;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
   logic [CH-1:0]     m_overflow;
`endif

   elixirchip_es1_spu_op_reduce #(
      .CHANNELS(CH), .DATA_BITS(DB), .COUNT_BITS(CB), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .cke(cke), .s_mode(s_mode), .s_data(s_data),
      .s_clear(s_clear), .s_valid(s_valid), .m_data(m_data), .m_count(m_count),
      .m_valid(m_valid)
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
      , .m_overflow(m_overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CH-1:0]    data;
      logic [CH*CB-1:0] count;
      logic             valid;
      logic [CH-1:0]    ovf;
   } snap_t;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    m_mode;
   bit    mbool [CH];
   int    mcnt  [CH];
   bit    movf  [CH];
   snap_t hist [$];
   snap_t e;

   task automatic model_reset();
      m_mode = 0;
      for (int c = 0; c < CH; c++) begin
         mbool[c] = 0; mcnt[c] = 0; movf[c] = 0;
      end
      hist.delete();
   endtask

   // One cke=1 edge worth of behaviour, then a snapshot of what stage 1 shows.
   task automatic model_step(input int mode, input logic [CH*DB-1:0] data,
                             input logic [CH-1:0] clr, input logic valid);
      snap_t s;
      bit    chg;
      chg = (mode != m_mode);
      for (int c = 0; c < CH; c++) begin
         logic [7:0] w;
         int         total;
         w = data[c*DB +: DB];
         if (clr[c] || chg) begin
            mbool[c] = (mode == 1); mcnt[c] = 0; movf[c] = 0;
         end
         if (valid) begin
            case (mode)
               0: mbool[c] = mbool[c] || (w != 0);
               1: mbool[c] = mbool[c] && (w == 8'hFF);
               2: mbool[c] = mbool[c] ^ (($countones(w) % 2) == 1);
               default: begin
                  total = mcnt[c] + $countones(w);
                  if (total > 15) begin mcnt[c] = 15; movf[c] = 1; end
                  else mcnt[c] = total;
               end
            endcase
         end
      end
      m_mode = mode;
      s = '0;
      for (int c = 0; c < CH; c++) begin
         s.data[c] = (mode == 3) ? (mcnt[c] != 0) : mbool[c];
         s.count[c*CB +: CB] = 4'(mcnt[c]);
         s.ovf[c] = movf[c];
      end
      s.valid = valid;
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
   endtask

   function automatic snap_t exp_out();
      if (hist.size() >= LAT) return hist[hist.size()-LAT];
      return '0;
   endfunction

   // Drives one cycle's inputs at a falling edge and returns at the next falling edge.
   task automatic drive_cycle(input int mode, input logic [CH*DB-1:0] data,
                              input logic [CH-1:0] clr, input logic valid, input logic ck);
      s_mode = 2'(mode); s_data = data; s_clear = clr; s_valid = valid; cke = ck;
      if (ck) model_step(mode, data, clr, valid);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; cke = 1'b0; s_mode = 0; s_data = '0; s_clear = '0; s_valid = 0;
      model_reset();
      #1;
      n_checks++;
      if ({m_data, m_count, m_valid} !== '0)
         $display("FAIL reset_state got data=%b count=%h valid=%b want all zero", m_data, m_count, m_valid);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_any();
      logic [7:0] w0 [6] = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
      drive_cycle(0, '0, 2'b11, 0, 1);
      for (int i = 0; i < 6; i++) begin
         drive_cycle(0, {8'h00, w0[i]}, 2'b00, (i < 4), 1);
         e = exp_out();
         n_checks++;
         if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid})
            $display("FAIL any[%0d] got d=%b c=%h v=%b want d=%b c=%h v=%b", i, m_data, m_count, m_valid, e.data, e.count, e.valid);
         else n_pass++;
         $display("any      cyc=%0d in=%h m_data=%b m_valid=%b", i, w0[i], m_data, m_valid);
      end
      n_checks++;
      if (m_data !== 2'b01) $display("FAIL any_final got m_data=%b want 01", m_data);
      else n_pass++;
   endtask

   task automatic test_all();
      logic [7:0] w0 [5] = '{8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFF};
      drive_cycle(1, '0, 2'b11, 0, 1);
      for (int i = 0; i < 7; i++) begin
         if (i < 5) drive_cycle(1, {8'hFF, w0[i]}, (i == 4) ? 2'b01 : 2'b00, 1, 1);
         else       drive_cycle(1, '0, 2'b00, 0, 1);
         e = exp_out();
         n_checks++;
         if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid})
            $display("FAIL all[%0d] got d=%b c=%h v=%b want d=%b c=%h v=%b", i, m_data, m_count, m_valid, e.data, e.count, e.valid);
         else n_pass++;
         $display("all      cyc=%0d m_data=%b m_valid=%b", i, m_data, m_valid);
      end
      n_checks++;
      if (m_data[0] !== 1'b1) $display("FAIL all_clear_valid got m_data[0]=%b want 1", m_data[0]);
      else n_pass++;
   endtask

   task automatic test_count();
      logic [7:0] w0 [3] = '{8'h0F, 8'hFF, 8'h0F};
      drive_cycle(3, '0, 2'b11, 0, 1);
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive_cycle(3, {8'h01, w0[i]}, 2'b00, 1, 1);
         else       drive_cycle(3, '0, 2'b00, 0, 1);
         e = exp_out();
         n_checks++;
         if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid})
            $display("FAIL count[%0d] got d=%b c=%h v=%b want d=%b c=%h v=%b", i, m_data, m_count, m_valid, e.data, e.count, e.valid);
         else n_pass++;
         $display("count    cyc=%0d m_count=%h m_data=%b", i, m_count, m_data);
      end
      n_checks++;
      if (m_count[3:0] !== 4'd15) $display("FAIL count_saturate got %0d want 15", m_count[3:0]);
      else n_pass++;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
      n_checks++;
      if (m_overflow !== 2'b01) $display("FAIL overflow_set got %b want 01", m_overflow);
      else n_pass++;
      drive_cycle(3, '0, 2'b01, 0, 1);
      drive_cycle(3, '0, 2'b00, 0, 1);
      n_checks++;
      if (m_overflow !== 2'b00) $display("FAIL overflow_clear got %b want 00", m_overflow);
      else n_pass++;
`endif
   endtask

   task automatic test_parity_clear();
      drive_cycle(2, '0, 2'b11, 0, 1);
      drive_cycle(2, {8'h07, 8'h01}, 2'b00, 1, 1);
      drive_cycle(2, {8'h00, 8'h01}, 2'b01, 1, 1);
      for (int i = 0; i < 2; i++) begin
         drive_cycle(2, '0, 2'b00, 0, 1);
         e = exp_out();
         n_checks++;
         if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid})
            $display("FAIL parity[%0d] got d=%b c=%h v=%b want d=%b c=%h v=%b", i, m_data, m_count, m_valid, e.data, e.count, e.valid);
         else n_pass++;
         $display("parity   cyc=%0d m_data=%b", i, m_data);
      end
      n_checks++;
      if (m_data !== 2'b11) $display("FAIL parity_clear_valid got %b want 11", m_data);
      else n_pass++;
   endtask

   task automatic test_cke_hold();
      logic [CH*CB-1:0] held;
      drive_cycle(3, '0, 2'b11, 0, 1);
      drive_cycle(3, {8'h03, 8'h01}, 2'b00, 1, 1);
      drive_cycle(3, {8'h03, 8'h01}, 2'b00, 1, 1);
      held = m_count;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(3, {8'h03, 8'h01}, 2'b00, 1, 0);
         n_checks++;
         if (m_count !== held) $display("FAIL cke_hold[%0d] got %h want %h", i, m_count, held);
         else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(3, {8'h03, 8'h01}, 2'b00, (i < 2), 1);
         e = exp_out();
         n_checks++;
         if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid})
            $display("FAIL cke_resume[%0d] got d=%b c=%h v=%b want d=%b c=%h v=%b", i, m_data, m_count, m_valid, e.data, e.count, e.valid);
         else n_pass++;
         $display("cke      cyc=%0d m_count=%h", i, m_count);
      end
   endtask

   task automatic test_random();
      int mode = 0;
      for (int i = 0; i < 300; i++) begin
         logic [CH-1:0] clr;
         if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 3);
         for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(0, 5) == 0);
         drive_cycle(mode, CH*DB'($urandom), clr, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 7) != 0));
         e = exp_out();
         n_checks++;
         if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid})
            $display("FAIL random[%0d] got d=%b c=%h v=%b want d=%b c=%h v=%b", i, m_data, m_count, m_valid, e.data, e.count, e.valid);
         else n_pass++;
`ifdef ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
         n_checks++;
         if (m_overflow !== e.ovf) $display("FAIL random_ovf[%0d] got %b want %b", i, m_overflow, e.ovf);
         else n_pass++;
`endif
         $display("random   cyc=%0d mode=%0d m_data=%b m_count=%h m_valid=%b", i, mode, m_data, m_count, m_valid);
      end
   endtask

   task automatic test_async_reset();
      drive_cycle(3, {8'hFF, 8'h0F}, 2'b11, 1, 1);
      drive_cycle(3, {8'hFF, 8'h0F}, 2'b00, 1, 1);
      cke = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({m_data, m_count, m_valid} !== '0)
         $display("FAIL async_reset got d=%b c=%h v=%b want all zero", m_data, m_count, m_valid);
      else n_pass++;
      #1 reset = 1'b0;
      model_reset();
      @(negedge clk);
      drive_cycle(0, {8'h00, 8'h40}, 2'b00, 1, 1);
      drive_cycle(0, '0, 2'b00, 0, 1);
      e = exp_out();
      n_checks++;
      if ({m_data, m_count, m_valid} !== {e.data, e.count, e.valid} || m_data !== 2'b01 || m_valid !== 1'b1)
         $display("FAIL post_reset_any got d=%b c=%h v=%b want d=01 c=%h v=1", m_data, m_count, m_valid, e.count);
      else n_pass++;
      $display("reset    post m_data=%b m_valid=%b", m_data, m_valid);
   endtask

   initial begin
      test_reset();
      test_any();
      test_all();
      test_count();
      test_parity_clear();
      test_cke_hold();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/elixirchip_es1_spu_op_reduce.md
Name: elixirchip_es1_spu_op_reduce

Overview:
- Multi-channel, mode-selectable bit-reduction operator for the ES1 SPU datapath; successor to the single-channel any-reduction op.
- Each channel reduces its DATA_BITS input word by OR, AND, XOR or popcount, and accumulates the result across valid cycles.
- Result is delivered through a cke-gated pipeline of LATENCY stages.
- Sits between SPU stream sources and flag/condition consumers.

Parameters:
- CHANNELS, 4, number of independent channels (>=1)
- DATA_BITS, 8, input word width per channel (>=1)
- COUNT_BITS, 16, popcount accumulator width per channel (>=$clog2(DATA_BITS+1))
- LATENCY, 2, cycles (counted in cke=1 cycles) from input to output (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active-high
- cke  input  1  clock enable; all state advances only when 1
- s_mode  input  2  0=ANY(OR), 1=ALL(AND), 2=PARITY(XOR), 3=COUNT(popcount); shared by all channels
- s_data  input  CHANNELS*DATA_BITS  channel c occupies bits [c*DATA_BITS +: DATA_BITS]
- s_clear  input  CHANNELS  per-channel accumulator clear
- s_valid  input  1  input word valid, shared
- m_data  output  CHANNELS  boolean result per channel
- m_count  output  CHANNELS*COUNT_BITS  popcount accumulator per channel
- m_valid  output  1  s_valid delayed by LATENCY

Behaviour:
- Reset (async, no clock edge needed): acc_bool, acc_cnt, mode register, all pipeline stages, m_data, m_count, m_valid = 0. In-flight data is discarded.
- Stage 1 (accumulator) updates only when cke=1:
  - Identity: ANY=0, ALL=1, PARITY=0, COUNT: acc_cnt=0.
  - base = identity if s_clear[c]=1, or if s_mode differs from the registered mode; otherwise base = current accumulator.
  - s_valid=1: acc_bool = base op reduce(s_data[c]). COUNT mode: acc_cnt = base + popcount(s_data[c]), saturating at 2^COUNT_BITS-1.
  - s_valid=0: accumulator = base. A clear without valid loads the identity.
  - Simultaneous clear and valid: clear first, then accumulate. The result is the reduction of the current word alone.
  - Mode register loads s_mode every cke cycle. A mode change implicitly clears all channels.
- COUNT mode: m_data[c] = (acc_cnt != 0). In other modes m_count holds its last COUNT value, or 0 after any clear.
- Stages 2..LATENCY: plain delay registers, cke-gated.
- Output timing: with LATENCY=1 the outputs are the stage-1 registers. Input sampled at cke edge k appears after the LATENCY-th subsequent cke edge.
- cke=0: every register holds. No double accumulation and no pipeline advance.
- m_valid carries s_valid through the same pipeline. Outputs remain meaningful when m_valid=0 (they show accumulator state).

Optional Feature:
- ELIXIRCHIP_SPU_REDUCE_OVERFLOW_EN
- Defined: adds output m_overflow [CHANNELS], pipelined identically to m_count.
  - Set sticky when a COUNT accumulation saturates or would exceed the maximum.
  - Cleared by s_clear[c], by a mode change, or by reset.
- Undefined: port absent; saturation is silent.

Test Plan:
(CHANNELS=2, DATA_BITS=8, COUNT_BITS=4, LATENCY=2, cke=1 unless stated)
- ANY, ch0 valid 0x00,0x00,0x10,0x00 -> m_data[0]=0,0,1,1, each 2 cycles after input; ch1 fed 0x00 stays 0.
- ALL, clear then valid 0xFF,0xFF,0xFE,0xFF -> m_data[0]=1,1,0,0; clear with valid 0xFF -> 1.
- COUNT, clear then 0x0F,0xFF -> m_count[0]=4 then 12; next 0x0F -> 15 (saturated); m_overflow[0]=1 if EN, cleared by next s_clear[0].
- PARITY with acc=1, s_clear[0]=1 and s_valid=1, data 0x01 -> m_data[0]=1 (not 0); ch1 unaffected.
- cke low 3 cycles mid-stream with data held -> outputs frozen, m_count unchanged; resumes with exactly one accumulation per cke cycle.
- Reset pulsed between clock edges mid-stream -> m_data, m_count, m_valid read 0 before the next edge; first post-reset output is the ANY reduction of the first new word.
